// File: rtl/mmio_pkg.sv
// Register offsets and debounce state encoding for the MMIO responder window.
// The cpucore test programs use these same offsets.
package mmio_pkg;

    localparam logic [7:0] OFF_LED       = 8'h00;
    localparam logic [7:0] OFF_HEX       = 8'h04;
    localparam logic [7:0] OFF_BTN_LEVEL = 8'h08;
    localparam logic [7:0] OFF_BTN_EDGE  = 8'h0C;
    localparam logic [7:0] OFF_TIMER     = 8'h10;
    localparam logic [7:0] OFF_TIMER_CMP = 8'h14;
    localparam logic [7:0] OFF_STATUS    = 8'h18;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchronizer, stability counter and STABLE/COUNTING FSM.
// rise is a one-cycle pulse coincident with the edge that flips level 0->1.
module btn_debounce
    import mmio_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000
) (
    input  logic CLK,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 20'd1);

    logic [1:0]    sync;
    db_state_e     state;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = sync[1] ^ level;
    assign flip   = (state == DB_COUNTING) && differ && (cnt == CNT_LAST);
    // Combinational so the edge-capture register sets on the same edge as level.
    assign rise   = flip && !level;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync  <= '0;
            state <= DB_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            case (state)
                DB_STABLE: begin
                    cnt <= '0;
                    if (differ) state <= DB_COUNTING;
                end
                DB_COUNTING: begin
                    if (!differ) begin
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level <= ~level;
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DB_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO register window on the cpucore data bus: LED/HEX display registers,
// debounced buttons with edge capture, and a free-running timer with compare flag.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter int          NBTN            = 4,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            hit,
    input  logic [NBTN-1:0] btn_in,
    output logic [3:0]      led,
    output logic [23:0]     hex,
    output logic            timer_irq
);

    logic [7:0]      off;
    logic            we;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_rise;
    logic [NBTN-1:0] btn_edge;
    logic [31:0]     timer;
    logic [31:0]     timer_cmp;

    assign hit = (addr[31:8] == BASE_ADDR[31:8]);
    assign off = addr[7:0] & 8'hFC;
    assign we  = write && hit;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK  (CLK),
            .reset(reset),
            .btn  (btn_in[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            led       <= '0;
            hex       <= '0;
            btn_edge  <= '0;
            timer     <= '0;
            timer_cmp <= '0;
            timer_irq <= 1'b0;
        end else begin
            if (we && off == OFF_LED)       led       <= wdata[3:0];
            if (we && off == OFF_HEX)       hex       <= wdata[23:0];
            if (we && off == OFF_TIMER_CMP) timer_cmp <= wdata;

            if (we && off == OFF_TIMER) timer <= wdata;
            else                        timer <= timer + 32'd1;

            // A new set in the same cycle as a W1C keeps the bit set.
            if (we && off == OFF_BTN_EDGE)
                btn_edge <= (btn_edge & ~wdata[NBTN-1:0]) | btn_rise;
            else
                btn_edge <= btn_edge | btn_rise;

            if (timer == timer_cmp)
                timer_irq <= 1'b1;
            else if (we && off == OFF_STATUS && wdata[0])
                timer_irq <= 1'b0;
        end
    end

    // read only expresses intent; load data is purely a decode of the registers.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_LED:       rdata = {28'd0, led};
                OFF_HEX:       rdata = {8'd0, hex};
                OFF_BTN_LEVEL: rdata = 32'(btn_level);
                OFF_BTN_EDGE:  rdata = 32'(btn_edge);
                OFF_TIMER:     rdata = timer;
                OFF_TIMER_CMP: rdata = timer_cmp;
                OFF_STATUS:    rdata = {31'd0, timer_irq};
                default:       rdata = '0;
            endcase
        end
    end

    logic unused_read;
    assign unused_read = read;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed-vector bench for mmio_responder with a short debounce window.
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  btn_in;
    logic [3:0]  led;
    logic [23:0] hex;
    logic        timer_irq;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    mmio_responder #(
        .BASE_ADDR      (BASE),
        .NBTN           (4),
        .DEBOUNCE_CYCLES(20'd4)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .addr     (addr),
        .read     (read),
        .write    (write),
        .wdata    (wdata),
        .rdata    (rdata),
        .hit      (hit),
        .btn_in   (btn_in),
        .led      (led),
        .hex      (hex),
        .timer_irq(timer_irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        addr  = BASE | 32'(off);
        wdata = d;
        write = 1'b1;
        tick(1);
        write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        addr = BASE | 32'(off);
        read = 1'b1;
        #1;
        chk(tag, rdata, exp);
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        addr = '0; wdata = '0; btn_in = '0;
        tick(2);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_hex", 32'(hex), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        rd("rst_timer", 8'h10, 32'h0);
        reset = 1'b0;

        // Display registers and decode
        wr(8'h00, 32'h0000_000A);
        chk("led", 32'(led), 32'hA);
        wr(8'h04, 32'h0012_3456);
        chk("hex", 32'(hex), 32'h12_3456);
        rd("rd_led", 8'h00, 32'hA);
        rd("rd_hex", 8'h04, 32'h12_3456);
        rd("rd_led_bytelane", 8'h03, 32'hA);
        addr = 32'h0000_0100; read = 1'b1; #1;
        chk("miss_hit", 32'(hit), 32'h0);
        chk("miss_rdata", rdata, 32'h0);
        read = 1'b0;
        rd("unmapped", 8'h20, 32'h0);
        chk("unmapped_hit", 32'(hit), 32'h1);
        wr(8'h00, 32'hFFFF_FFF5);
        rd("led_upper", 8'h00, 32'h5);

        // Button 0: glitch rejected, then a clean press
        btn_in[0] = 1'b1; tick(2); btn_in[0] = 1'b0; tick(10);
        rd("glitch_level", 8'h08, 32'h0);
        rd("glitch_edge", 8'h0C, 32'h0);
        btn_in[0] = 1'b1;
        tick(6);
        rd("press_level_6", 8'h08, 32'h0);
        tick(1);
        rd("press_level_7", 8'h08, 32'h1);
        rd("press_edge", 8'h0C, 32'h1);
        tick(3);
        btn_in[0] = 1'b0;
        tick(10);
        rd("release_level", 8'h08, 32'h0);
        rd("release_edge", 8'h0C, 32'h1);

        // W1C colliding with a new rise: set wins
        btn_in[0] = 1'b1;
        tick(6);
        wr(8'h0C, 32'h1);
        rd("w1c_rise_level", 8'h08, 32'h1);
        rd("w1c_rise_edge", 8'h0C, 32'h1);
        wr(8'h0C, 32'h1);
        rd("w1c_edge", 8'h0C, 32'h0);

        // Timer compare
        wr(8'h14, 32'd5);
        wr(8'h10, 32'd0);
        wr(8'h18, 32'h1);
        chk("irq_cleared", 32'(timer_irq), 32'h0);
        tick(4);
        rd("timer_5", 8'h10, 32'd5);
        chk("irq_pre", 32'(timer_irq), 32'h0);
        tick(1);
        chk("irq_set", 32'(timer_irq), 32'h1);
        rd("status_set", 8'h18, 32'h1);
        wr(8'h18, 32'h1);
        chk("irq_w1c", 32'(timer_irq), 32'h0);
        rd("status_clr", 8'h18, 32'h0);

        // Wrap and read-during-write
        wr(8'h10, 32'hFFFF_FFFF);
        rd("timer_max", 8'h10, 32'hFFFF_FFFF);
        tick(1);
        rd("timer_wrap", 8'h10, 32'h0);
        tick(1);
        addr = BASE | 32'h10; wdata = 32'h100; read = 1'b1; write = 1'b1; #1;
        chk("rw_old", rdata, 32'h1);
        tick(1);
        read = 1'b0; write = 1'b0;
        rd("rw_new", 8'h10, 32'h100);

        // Reset mid-debounce and mid-count, with a write in the reset cycle
        wr(8'h14, 32'h30);
        wr(8'h10, 32'h30);
        tick(1);
        chk("irq_before_rst", 32'(timer_irq), 32'h1);
        btn_in[1] = 1'b1;
        tick(4);
        reset = 1'b1;
        addr = BASE; wdata = 32'h5; write = 1'b1;
        tick(1);
        write = 1'b0;
        chk("rst2_led", 32'(led), 32'h0);
        chk("rst2_hex", 32'(hex), 32'h0);
        chk("rst2_irq", 32'(timer_irq), 32'h0);
        rd("rst2_timer", 8'h10, 32'h0);
        rd("rst2_cmp", 8'h14, 32'h0);
        rd("rst2_level", 8'h08, 32'h0);
        rd("rst2_edge", 8'h0C, 32'h0);
        reset = 1'b0;
        tick(6);
        rd("post_rst_level_6", 8'h08, 32'h0);
        tick(1);
        rd("post_rst_level_7", 8'h08, 32'h3);
        chk("post_rst_led", 32'(led), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
